// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and widths for the SPI byte transmitter
package spi_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: phase counter producing phase ticks and SCLK edge strobes
module spi_clk_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       shift,
  input  logic [7:0] term,
  output logic       phase_tick,
  output logic       sclk_rise,
  output logic       sclk_fall
);
  logic [7:0] cnt;
  logic       hi;
  assign phase_tick = run && cnt == term;
  assign sclk_rise  = phase_tick && shift && !hi;
  assign sclk_fall  = phase_tick && shift && hi;
  // Count within a phase, wrap on the terminal value, and track SCLK half during SHIFT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      hi  <= 1'b0;
    end else begin
      cnt <= (phase_tick || !run) ? 8'd0 : cnt + 8'd1;
      hi  <= shift ? hi ^ phase_tick : 1'b0;
    end
endmodule

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 MSB-first byte serializer; SPI_BYTE_TX_RX_EN adds MISO capture
module spi_byte_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              baseClk,
  input  logic              hard_Clr,
  input  logic [BYTE_W-1:0] data,
  input  logic              sendEnable,
  output logic              sendBusy,
  output logic              spi_sclk,
  output logic              spi_mosi,
`ifdef SPI_BYTE_TX_RX_EN
  input  logic              spi_miso,
  output logic [BYTE_W-1:0] rxData,
  output logic              rxValid,
`endif
  output logic              spi_cs_n
);
  localparam logic [7:0] DIV_T = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_T = 8'(GAP_CYCLES - 1);
  state_t            state;
  logic [BYTE_W-1:0] sr;
  logic [2:0]        bitc;
  logic              tick, rise, fall;
  spi_clk_div u_div (
    .clk       (baseClk),
    .rst       (hard_Clr),
    .run       (state != IDLE),
    .shift     (state == SHIFT),
    .term      (state == GAP ? GAP_T : DIV_T),
    .phase_tick(tick),
    .sclk_rise (rise),
    .sclk_fall (fall)
  );
  // Frame sequencer with registered SPI and busy outputs
  always_ff @(posedge baseClk or posedge hard_Clr)
    if (hard_Clr) begin
      state    <= IDLE;
      sr       <= '0;
      bitc     <= '0;
      sendBusy <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (sendEnable) begin
            state    <= SETUP;
            sr       <= data;
            bitc     <= 3'd7;
            sendBusy <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= data[7];
          end
        SETUP:
          if (tick) state <= SHIFT;
        SHIFT: begin
          if (rise) spi_sclk <= 1'b1;
          if (fall) begin
            spi_sclk <= 1'b0;
            sr       <= {sr[BYTE_W-2:0], 1'b0};
            spi_mosi <= sr[BYTE_W-2];
            bitc     <= bitc - 3'd1;
            if (bitc == 3'd0) state <= HOLD;
          end
        end
        HOLD:
          if (tick) begin
            state    <= GAP;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
          end
        GAP:
          if (tick) begin
            state    <= IDLE;
            sendBusy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef SPI_BYTE_TX_RX_EN
  logic [BYTE_W-1:0] rx_sr;
  // Capture MISO on SCLK rise; publish the byte for one cycle when the last bit ends
  always_ff @(posedge baseClk or posedge hard_Clr)
    if (hard_Clr) begin
      rx_sr   <= '0;
      rxData  <= '0;
      rxValid <= 1'b0;
    end else begin
      if (rise) rx_sr <= {rx_sr[BYTE_W-2:0], spi_miso};
      rxValid <= fall && bitc == 3'd0;
      if (fall && bitc == 3'd0) rxData <= rx_sr;
    end
`endif
endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: randomized scoreboard bench for spi_byte_tx plus a CLK_DIV=2 corner instance
module tb_spi_byte_tx;
  localparam int D = 4, G = 4, BUSY = D * 18 + G, CSLEN = D * 18;
  logic       clk = 0, rst = 1;
  logic [7:0] data = 0, data1 = 0;
  logic       en = 0, en1 = 0;
  logic       busy, sclk, mosi, cs_n, busy1, sclk1, mosi1, cs1;
`ifdef SPI_BYTE_TX_RX_EN
  logic       miso = 0;
  logic [7:0] rxd, rxd1, rx_pat = 8'h5A;
  logic       rxv, rxv1;
  int         ridx, nval;
`endif
  int checks = 0, errors = 0, cyc = 0, la = -1000;
  typedef struct {logic [7:0] b; int t;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic ps = 0, pb = 0, pcs = 1, in_f = 0;
  logic [7:0] sh;
  int blen = 0, clen = 0, rises = 0;

  spi_byte_tx #(.CLK_DIV(D), .GAP_CYCLES(G)) u0 (
    .baseClk(clk), .hard_Clr(rst), .data(data), .sendEnable(en), .sendBusy(busy),
    .spi_sclk(sclk), .spi_mosi(mosi),
`ifdef SPI_BYTE_TX_RX_EN
    .spi_miso(miso), .rxData(rxd), .rxValid(rxv),
`endif
    .spi_cs_n(cs_n));

  spi_byte_tx #(.CLK_DIV(2), .GAP_CYCLES(1)) u1 (
    .baseClk(clk), .hard_Clr(rst), .data(data1), .sendEnable(en1), .sendBusy(busy1),
    .spi_sclk(sclk1), .spi_mosi(mosi1),
`ifdef SPI_BYTE_TX_RX_EN
    .spi_miso(1'b0), .rxData(rxd1), .rxValid(rxv1),
`endif
    .spi_cs_n(cs1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Reference model: a request is taken only if the previous accept is at least BUSY+1 cycles old
  task automatic step(input logic e, input logic [7:0] d);
    @(negedge clk);
    en = e;
    data = d;
    if (e && cyc - la >= BUSY + 1) begin
      q.push_back('{d, cyc});
      la = cyc;
    end
  endtask

  // Monitor: decode frames off the wire and compare against the scoreboard queue
  always @(negedge clk) begin
    if (rst) begin
      in_f = 0; ps = 0; pb = 0; pcs = 1; blen = 0;
`ifdef SPI_BYTE_TX_RX_EN
      miso = 0;
`endif
    end else begin
      if (pb && !busy) chk("busy_len", blen, BUSY);
      blen = busy ? blen + 1 : 0;
      if (!cs_n && pcs) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame at cycle %0d", cyc);
        end else begin
          cur = q.pop_front();
          chk("start_cycle", cyc, cur.t + 1);
        end
        chk("busy_at_start", busy, 1);
        in_f = 1; rises = 0; sh = 0; clen = 0;
`ifdef SPI_BYTE_TX_RX_EN
        miso = rx_pat[7]; ridx = 6; nval = 0;
`endif
      end
      if (!cs_n) clen++;
      if (in_f && sclk && !ps) begin
        rises++;
        sh = {sh[6:0], mosi};
      end
`ifdef SPI_BYTE_TX_RX_EN
      if (in_f && !sclk && ps && ridx >= 0) begin
        miso = rx_pat[ridx];
        ridx--;
      end
      if (rxv) begin
        chk("rx_data", rxd, 8'h5A);
        chk("rx_timing", rises, 8);
        nval++;
      end
`endif
      if (cs_n && !pcs && in_f) begin
        chk("cs_len", clen, CSLEN);
        chk("rises", rises, 8);
        chk("byte", sh, cur.b);
`ifdef SPI_BYTE_TX_RX_EN
        chk("rx_pulses", nval, 1);
`endif
        in_f = 0;
      end
      if (cs_n) chk("idle_lines", {sclk, mosi}, 0);
      ps = sclk; pb = busy; pcs = cs_n;
    end
  end

  task automatic corner();
    int nb = 0, nr = 0, lr = 0, m1 = 0, nc = 0;
    logic p1 = 0;
    @(negedge clk);
    en1 = 1; data1 = 8'h00;
    @(negedge clk);
    en1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy1) nb++;
      if (!cs1) nc++;
      if (sclk1 && !p1) begin
        if (nr > 0) chk("div2_period", i - lr, 4);
        lr = i;
        nr++;
      end
      if (mosi1) m1++;
      p1 = sclk1;
      @(negedge clk);
    end
    chk("div2_busy", nb, 37);
    chk("div2_cs_len", nc, 36);
    chk("div2_rises", nr, 8);
    chk("div2_mosi_ones", m1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mosi", mosi, 0);
    @(posedge clk); #1 rst = 0;
    step(1, 8'hA5);
    repeat (90) step(0, 8'h00);
    step(1, 8'h3C);
    repeat (19) step(0, 8'h00);
    step(1, 8'hFF);
    repeat (80) step(0, 8'h00);
    repeat (3 * 77 + 5) step(1, 8'h81);
    repeat (80) step(0, 8'h00);
    repeat (40) begin
      step(1, 8'($urandom));
      repeat ($urandom_range(0, 120)) step(($urandom % 6) == 0, 8'($urandom));
    end
    repeat (100) step(0, 8'h00);
    step(1, 8'hC3);
    repeat (30) step(0, 8'h00);
    #3 rst = 1;
    #1;
    chk("midrst_cs", cs_n, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mosi", mosi, 0);
    q.delete();
    la = -1000;
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    step(1, 8'h5E);
    repeat (90) step(0, 8'h00);
    chk("queue_empty", q.size(), 0);
    corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
